// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and frame constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imem_loader_pkg;

    // Loader FSM states, in frame order
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        COUNT = 4'd1,
        HI    = 4'd2,
        LO    = 4'd3,
        WRITE = 4'd4,
        CHK   = 4'd5,
        START = 4'd6,
        DONE  = 4'd7,
        ERR   = 4'd8
    } state_t;

    // Default frame start marker
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Instruction words arrive high byte first
    function automatic logic [15:0] pack_word(input logic [7:0] hi_b, input logic [7:0] lo_b);
        return {hi_b, lo_b};
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Loads a framed byte stream (SYNC, N, 2N data bytes, XOR checksum) into instruction RAM, holding the CPU meanwhile.
// Latency: last data byte accepted at edge k -> imem_we in cycle k+1; checksum accepted at edge m -> cpu_start in cycle m+1.
// Backpressure: rx_ready drops for exactly one cycle per word write (and during START); rx_valid gaps simply stall.
//
// Integration: cpu_hold is ORed into the CPU reset, cpu_start is ORed with the external start input.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int               ADDR_W    = 8,
    parameter int               DATA_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]       SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    state_t     state;
    logic [7:0] count_m1;   // N-1; N=0 wraps to 8'hFF, i.e. 256 words
    logic [7:0] index;      // word index within the current frame
    logic [7:0] hi_byte;
    logic [7:0] csum;       // running XOR of count and data bytes
    logic       rx_xfer;

    // A byte moves only when both sides agree at the clock edge
    assign rx_xfer = rx_valid && rx_ready;

    // Frame parser, word packer and CPU control; every output is registered here
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rx_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= '0;
            cpu_hold     <= 1'b1;
            cpu_start    <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            count_m1     <= '0;
            index        <= '0;
            hi_byte      <= '0;
            csum         <= '0;
        end else begin
            imem_we   <= 1'b0;
            cpu_start <= 1'b0;
            case (state)
                // Waiting for a frame; non-sync bytes are consumed and dropped
                IDLE, DONE, ERR: begin
                    rx_ready <= 1'b1;
                    if (rx_xfer && rx_data == SYNC_BYTE) begin
                        state        <= COUNT;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        err          <= 1'b0;
                        words_loaded <= '0;
                        csum         <= '0;
                    end
                end
                COUNT: begin
                    if (rx_xfer) begin
                        count_m1 <= rx_data - 8'd1;
                        csum     <= csum ^ rx_data;
                        index    <= '0;
                        state    <= HI;
                    end
                end
                HI: begin
                    if (rx_xfer) begin
                        hi_byte <= rx_data;
                        csum    <= csum ^ rx_data;
                        state   <= LO;
                    end
                end
                // Second byte completes the word; the write is issued from the registers directly
                LO: begin
                    if (rx_xfer) begin
                        imem_wdata <= DATA_W'(pack_word(hi_byte, rx_data));
                        imem_addr  <= BASE_ADDR + ADDR_W'(index);
                        imem_we    <= 1'b1;
                        csum       <= csum ^ rx_data;
                        rx_ready   <= 1'b0;
                        state      <= WRITE;
                    end
                end
                // Write cycle: no byte accepted, bookkeeping advances
                WRITE: begin
                    words_loaded <= words_loaded + (ADDR_W+1)'(1);
                    index        <= index + 8'd1;
                    rx_ready     <= 1'b1;
                    state        <= (index == count_m1) ? CHK : HI;
                end
                CHK: begin
                    if (rx_xfer) begin
                        busy <= 1'b0;
                        if (rx_data == csum) begin
                            cpu_hold  <= 1'b0;
                            cpu_start <= 1'b1;
                            rx_ready  <= 1'b0;
                            state     <= START;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                START: begin
                    rx_ready <= 1'b1;
                    state    <= DONE;
                end
                default: begin
                    rx_ready <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard and start/latency tracking.
// Latency: n/a.
// Backpressure: driver honours rx_ready and can insert rx_valid gaps.
module tb_imem_loader;

    localparam int         ADDR_W = 8;
    localparam int         DATA_W = 16;
    localparam logic [7:0] BASE   = 8'h00;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic              busy;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .BASE_ADDR(BASE),
        .SYNC_BYTE(SYNC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_hold    (cpu_hold),
        .cpu_start   (cpu_start),
        .busy        (busy),
        .err         (err),
        .words_loaded(words_loaded)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        exp_w;
    logic [7:0] fd[$];

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_writes = 0;
    int n_starts = 0;
    int start_cyc = -1;
    int last_we_cyc = -1;
    int last_acc = -1;
    int data_acc = -1;
    int chk_acc = -1;
    int rdy_low = 0;
    int hold_bad = 0;
    int w0, s0;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: scoreboard pop on every write, start pulse tracking
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            last_we_cyc = cyc;
            chk(32'(rx_ready), 32'h0, "rdy_low_in_write");
            chk(32'(exp_q.size() != 0), 32'h1, "write_expected");
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                chk(32'(imem_addr), 32'(exp_w.addr), "write_addr");
                chk(32'(imem_wdata), 32'(exp_w.data), "write_data");
            end
        end
        if (cpu_start === 1'b1) begin
            n_starts++;
            start_cyc = cyc;
            chk(32'(cpu_hold), 32'h0, "hold_low_at_start");
        end
        if (busy === 1'b1 && rx_ready === 1'b0) rdy_low++;
        if (busy === 1'b1 && cpu_hold !== 1'b1) hold_bad++;
    end

    function automatic logic [7:0] fsum(input logic [7:0] n);
        logic [7:0] s;
        s = n;
        foreach (fd[i]) s ^= fd[i];
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        w = 0;
        while (rx_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            chk(32'(rx_ready), 32'h1, "rx_ready_timeout");
        end else begin
            @(posedge clk);
            #1;
            last_acc = cyc;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Full frame from fd; expected writes are queued before anything is driven
    task automatic send_frame(input logic [7:0] n, input logic [7:0] cs, input int gap);
        int words;
        words = (n == 8'd0) ? 256 : int'(n);
        for (int i = 0; i < words; i++) begin
            exp_w.addr = BASE + 8'(i);
            exp_w.data = {fd[2*i], fd[2*i+1]};
            exp_q.push_back(exp_w);
        end
        send_byte(SYNC, gap);
        send_byte(n, gap);
        for (int i = 0; i < fd.size(); i++) send_byte(fd[i], gap);
        data_acc = last_acc;
        send_byte(cs, gap);
        chk_acc = last_acc;
        idle(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk(32'(rx_ready), 32'h0, "rst_rx_ready");
        chk(32'(imem_we), 32'h0, "rst_imem_we");
        chk(32'(imem_addr), 32'(BASE), "rst_imem_addr");
        chk(32'(imem_wdata), 32'h0, "rst_imem_wdata");
        chk(32'(cpu_hold), 32'h1, "rst_cpu_hold");
        chk(32'(cpu_start), 32'h0, "rst_cpu_start");
        chk(32'(busy), 32'h0, "rst_busy");
        chk(32'(err), 32'h0, "rst_err");
        chk(32'(words_loaded), 32'h0, "rst_words_loaded");
        reset = 1'b0;
        @(negedge clk);
        chk(32'(rx_ready), 32'h1, "rx_ready_after_reset");

        // Good 2-word frame, continuous valid
        fd = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        w0 = n_writes; s0 = n_starts; rdy_low = 0; hold_bad = 0;
        send_frame(8'h02, 8'h42, 0);
        chk(32'(n_writes - w0), 32'd2, "f1_writes");
        chk(32'(n_starts - s0), 32'd1, "f1_starts");
        chk(32'(start_cyc), 32'(chk_acc), "f1_start_latency");
        chk(32'(last_we_cyc), 32'(data_acc), "f1_write_latency");
        chk(32'(words_loaded), 32'd2, "f1_words_loaded");
        chk(32'(err), 32'h0, "f1_err");
        chk(32'(cpu_hold), 32'h0, "f1_cpu_hold");
        chk(32'(busy), 32'h0, "f1_busy");
        chk(32'(rdy_low), 32'd2, "f1_rdy_low_cycles");

        // Same frame, bad checksum (starts from DONE, so hold must re-assert)
        w0 = n_writes; s0 = n_starts;
        send_frame(8'h02, 8'h43, 0);
        chk(32'(n_writes - w0), 32'd2, "f2_writes");
        chk(32'(n_starts - s0), 32'd0, "f2_no_start");
        chk(32'(err), 32'h1, "f2_err");
        chk(32'(cpu_hold), 32'h1, "f2_cpu_hold");
        chk(32'(busy), 32'h0, "f2_busy");
        chk(32'(rx_ready), 32'h1, "f2_rx_ready");

        // Garbage then a valid 1-word frame recovers from ERR
        w0 = n_writes; s0 = n_starts;
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        chk(32'(busy), 32'h0, "f3_garbage_ignored");
        fd = '{8'h00, 8'h07};
        send_frame(8'h01, 8'h06, 0);
        chk(32'(n_writes - w0), 32'd1, "f3_writes");
        chk(32'(n_starts - s0), 32'd1, "f3_starts");
        chk(32'(err), 32'h0, "f3_err_cleared");
        chk(32'(cpu_hold), 32'h0, "f3_cpu_hold");
        chk(32'(words_loaded), 32'd1, "f3_words_loaded");

        // N=0 -> 256 words over the full address range
        fd.delete();
        for (int i = 0; i < 512; i++) fd.push_back(8'(i * 13 + 5));
        w0 = n_writes; s0 = n_starts;
        send_frame(8'h00, fsum(8'h00), 0);
        chk(32'(n_writes - w0), 32'd256, "f4_writes");
        chk(32'(words_loaded), 32'd256, "f4_words_loaded");
        chk(32'(n_starts - s0), 32'd1, "f4_starts");
        chk(32'(start_cyc), 32'(chk_acc), "f4_start_latency");
        chk(32'(exp_q.size()), 32'd0, "f4_scoreboard_empty");

        // rx_valid toggling every other cycle
        fd = '{8'hBE, 8'hEF};
        w0 = n_writes; s0 = n_starts; rdy_low = 0;
        send_frame(8'h01, 8'h50, 1);
        chk(32'(n_writes - w0), 32'd1, "f5_writes");
        chk(32'(rdy_low), 32'd1, "f5_rdy_low_cycles");
        chk(32'(n_starts - s0), 32'd1, "f5_starts");
        chk(32'(words_loaded), 32'd1, "f5_words_loaded");
        chk(32'(hold_bad), 32'd0, "hold_during_busy");

        // Reset after first word of a 3-word frame, colliding with a transfer
        w0 = n_writes; s0 = n_starts;
        exp_w.addr = BASE;
        exp_w.data = 16'h1122;
        exp_q.push_back(exp_w);
        send_byte(SYNC, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        idle(3);
        chk(32'(n_writes - w0), 32'd1, "f6_first_write");
        chk(32'(busy), 32'h1, "f6_busy_mid_frame");
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        chk(32'(rx_ready), 32'h0, "f6_rst_rx_ready");
        chk(32'(busy), 32'h0, "f6_rst_busy");
        chk(32'(cpu_hold), 32'h1, "f6_rst_cpu_hold");
        chk(32'(words_loaded), 32'h0, "f6_rst_words_loaded");
        chk(32'(imem_addr), 32'(BASE), "f6_rst_imem_addr");
        chk(32'(imem_wdata), 32'h0, "f6_rst_imem_wdata");
        chk(32'(err), 32'h0, "f6_rst_err");
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        chk(32'(rx_ready), 32'h1, "f6_rx_ready_back");
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        send_byte(8'h00, 0);
        idle(4);
        chk(32'(n_writes - w0), 32'd1, "f6_no_more_writes");
        chk(32'(n_starts - s0), 32'd0, "f6_no_start");
        chk(32'(busy), 32'h0, "f6_idle");
        chk(32'(cpu_hold), 32'h1, "f6_cpu_hold");
        chk(32'(words_loaded), 32'h0, "f6_words_loaded");
        chk(32'(exp_q.size()), 32'd0, "final_scoreboard_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream, packs pairs of bytes into 16-bit instruction words, and writes them into the instruction RAM that the pipeline CPU reads.
- Holds the CPU in reset while a program is loading.
- After the frame's checksum verifies, releases the CPU and pulses its start input.
- Sits between a byte source (UART receiver or debug port) and the instruction RAM write port / CPU reset and start inputs.

Parameters:
- ADDR_W, 8: instruction RAM address width.
- DATA_W, 16: instruction word width. Fixed at 2 bytes; other values are unsupported.
- BASE_ADDR, 8'h00: address of the first loaded word.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts the byte; transfer occurs when rx_valid && rx_ready at a rising edge
- imem_we  output  1  instruction RAM write enable, one-cycle pulse per word
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  DATA_W  write data
- cpu_hold  output  1  active-high reset to the CPU
- cpu_start  output  1  one-cycle start pulse to the CPU
- busy  output  1  frame in progress
- err  output  1  last frame failed its checksum
- words_loaded  output  ADDR_W+1  words written in the current or last frame

Behaviour:
- Frame format: SYNC_BYTE, then count byte N (0 means 256 words), then 2N data bytes (high byte first), then checksum byte.
- Checksum = XOR of the count byte and all data bytes.
- Reset values: rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, cpu_start=0, busy=0, err=0, words_loaded=0, state=IDLE. rx_ready rises the cycle after reset deasserts.
- States:
  - IDLE: rx_ready=1. A non-sync byte is consumed and discarded. SYNC_BYTE -> COUNT; busy=1, cpu_hold=1, err=0, words_loaded=0, checksum accumulator=0.
  - COUNT: accept N, fold it into the checksum, latch N -> HI.
  - HI: accept byte, store as the high byte -> LO.
  - LO: accept byte, form the word -> WRITE.
  - WRITE: rx_ready=0 for exactly one cycle. imem_we=1, imem_addr=BASE_ADDR+index (mod 2^ADDR_W, wraps), imem_wdata=word. words_loaded increments at the end of this cycle. If this was the last word -> CHK, else -> HI.
  - CHK: accept the checksum byte. On match -> START. On mismatch -> ERR.
  - START: one cycle. cpu_hold=0, cpu_start=1, busy=0 -> DONE.
  - DONE: cpu_hold=0, rx_ready=1. Non-sync bytes are discarded. SYNC_BYTE -> COUNT and re-asserts cpu_hold in the next cycle.
  - ERR: err=1, cpu_hold=1, busy=0, rx_ready=1. SYNC_BYTE -> COUNT and clears err.
- rx_valid gaps stall the current state. No duplicate byte consumption and no duplicate writes.
- imem_we is never asserted outside WRITE. Exactly N writes per frame (256 when N=0).
- Latency: last data byte accepted at edge k -> imem_we high in cycle k+1. Checksum byte accepted at edge m -> cpu_start high in cycle m+1.
- Reset mid-frame: abort immediately and return to reset values. Words already written stay in RAM; the CPU stays held.
- Reset asserted in the same cycle as an rx transfer: reset wins and the byte is dropped.

Decomposition:
- Shared package: state encoding (IDLE, COUNT, HI, LO, WRITE, CHK, START, DONE, ERR) and SYNC_BYTE default.
- No sub-module needed. Checksum XOR and byte packing stay inline.
- Top-level integration: cpu_hold ORs into the CPU reset; cpu_start ORs with the external start.

Test Plan:
- Reset, then stream A5 02 12 34 AB CD 42 with rx_valid held high:
  - imem_we pulses twice: addr 00 data 1234, addr 01 data ABCD.
  - cpu_start is one pulse the cycle after 42 is accepted; cpu_hold falls in that cycle.
  - words_loaded=2, err=0.
- Same frame with checksum 43:
  - two writes occur, then err=1, cpu_hold stays 1, cpu_start never pulses.
  - A following valid frame clears err and starts the CPU.
- Garbage 00 FF 5A before A5 01 00 07 06: garbage ignored, one write addr 00 data 0007, start pulse.
- N=00 with 512 data bytes and correct checksum:
  - 256 writes at addresses 00..FF with no wrap error.
  - words_loaded=256, then start.
- rx_valid toggled every other cycle during frame A5 01 BE EF 50:
  - exactly one write, addr 00 data BEEF.
  - rx_ready low for exactly one cycle during WRITE.
- Assert reset after the first word of a 3-word frame: outputs return to reset values, IDLE, cpu_hold=1, words_loaded=0, and no further writes occur.
